// File: rtl/param_universal_shift_register.sv
// Parametrised universal shift register with a multi-step shift engine.
// A start request latches mode and amount. Load, hold and zero-amount requests
// complete at once. Shift and rotate requests then take one step per clock.
module param_universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] din,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SRL  = 3'b001;
    localparam logic [2:0] M_SLL  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic             done_q, done_d;

    // One single-bit step of the given mode. Hold and reserved codes return v.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v,
                                              input logic [2:0] m,
                                              input logic sr, input logic sl);
        logic [WIDTH-1:0] r;
        r = v;
        case (m)
            M_SRL:   r = {sr, v[WIDTH-1:1]};
            M_SLL:   r = {v[WIDTH-2:0], sl};
            M_ROR:   r = {v[0], v[WIDTH-1:1]};
            M_ROL:   r = {v[WIDTH-2:0], v[WIDTH-1]};
            M_ASR:   r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // True for modes that move bits step by step (everything except hold/load/reserved).
    function automatic logic is_step_mode(input logic [2:0] m);
        return (m == M_SRL) || (m == M_SLL) || (m == M_ROR) ||
               (m == M_ROL) || (m == M_ASR);
    endfunction

    // Next-state logic: accept in IDLE, one step per edge in SHIFT.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
                    if (mode == M_LOAD) begin
                        q_d    = din;
                        done_d = 1'b1;
                    end else if (!is_step_mode(mode) || amount == '0) begin
                        // Nothing to move: finish as a zero-latency operation.
                        done_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        cnt_d   = amount;
                    end
                end
            end
            SHIFT: begin
                // Serial inputs are taken live on every step, not latched at accept.
                q_d   = step(q_q, mode_q, sin_r, sin_l);
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset. Reset aborts a shift without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= M_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign q      = q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];
    assign busy   = (state_q == SHIFT);
    assign done   = done_q;

endmodule

// File: tb/tb_param_universal_shift_register.sv
// Scoreboard bench for param_universal_shift_register (WIDTH=8, CNT_W=4).
// Each request pushes its expected result. The result is popped when done is seen.
module tb_param_universal_shift_register;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] mode;
    logic [3:0] amount;
    logic [7:0] din;
    logic       sin_r, sin_l;
    logic [7:0] q;
    logic       sout_r, sout_l, busy, done;

    param_universal_shift_register #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .amount(amount),
        .din(din), .sin_r(sin_r), .sin_l(sin_l), .q(q), .sout_r(sout_r),
        .sout_l(sout_l), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        int         busy;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mdl_q;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference single step, written with shift operators on an 8-bit value.
    function automatic logic [7:0] mstep(input logic [7:0] v, input logic [2:0] m,
                                         input logic sr, input logic sl);
        logic [7:0] r;
        case (m)
            3'd1:    r = (v >> 1) | (sr ? 8'h80 : 8'h00);
            3'd2:    r = (v << 1) | (sl ? 8'h01 : 8'h00);
            3'd4:    r = (v >> 1) | (v << 7);
            3'd5:    r = (v << 1) | (v >> 7);
            3'd6:    r = (v >> 1) | (v & 8'h80);
            default: r = v;
        endcase
        return r;
    endfunction

    // Called at a negedge. Drives one request and follows it until done.
    // It returns at the done negedge, so a following call starts back-to-back.
    // With junk set, conflicting start requests are driven while busy.
    task automatic run_op(input logic [2:0] m, input logic [3:0] amt, input logic [7:0] d,
                          input logic sr, input logic sl, input bit junk);
        exp_t       e;
        logic [7:0] cur;
        int         nb;
        bit         seen;
        start = 1'b1; mode = m; amount = amt; din = d; sin_r = sr; sin_l = sl;
        e.q = mdl_q;
        e.busy = 0;
        if (m == 3'd3) e.q = d;
        else if ((m == 3'd1 || m == 3'd2 || m == 3'd4 || m == 3'd5 || m == 3'd6) && amt != 0) begin
            for (int i = 0; i < int'(amt); i++) e.q = mstep(e.q, m, sr, sl);
            e.busy = int'(amt);
        end
        sb.push_back(e);
        cur = (m == 3'd3) ? d : mdl_q;
        mdl_q = e.q;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            chk("q_step", 32'(q), 32'(cur));
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) begin
                nb++;
                cur = mstep(cur, m, sr, sl);
                if (junk) begin
                    start = 1'b1; mode = 3'd2; amount = 4'd5;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!seen) chk("done_seen", 32'(done), 32'd1);
        e = sb.pop_front();
        chk("q_final", 32'(q), 32'(e.q));
        chk("busy_cycles", 32'(nb), 32'(e.busy));
        chk("busy_at_done", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; mode = 3'd3; amount = 4'd0; din = 8'hFF;
        sin_r = 1'b0; sin_l = 1'b0;
        mdl_q = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);

        run_op(3'd3, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0);   // load
        @(negedge clk);
        chk("done_clears", 32'(done), 32'd0);
        run_op(3'd5, 4'd3, 8'h00, 1'b0, 1'b0, 1'b0);   // ROL 3 -> 2D
        @(negedge clk);
        run_op(3'd5, 4'd8, 8'h00, 1'b0, 1'b0, 1'b0);   // ROL 8 -> 2D
        chk("rol8_abs", 32'(q), 32'h2D);
        @(negedge clk);
        run_op(3'd3, 4'd0, 8'h96, 1'b0, 1'b0, 1'b0);
        run_op(3'd6, 4'd2, 8'h00, 1'b0, 1'b0, 1'b0);   // ASR 2 -> E5
        chk("asr_abs", 32'(q), 32'hE5);
        chk("asr_sout_r", 32'(sout_r), 32'd1);
        chk("asr_sout_l", 32'(sout_l), 32'd1);
        run_op(3'd3, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        run_op(3'd1, 4'd4, 8'h00, 1'b1, 1'b0, 1'b0);   // SRL sin_r=1 -> F0
        chk("srl_abs", 32'(q), 32'hF0);
        @(negedge clk);
        run_op(3'd2, 4'd3, 8'h00, 1'b0, 1'b1, 1'b1);   // SLL with starts while busy
        @(negedge clk);
        chk("ignored_start", 32'(busy), 32'd0);
        run_op(3'd1, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0);   // amount 0: no busy
        // back-to-back chain, including hold, reserved and amounts beyond WIDTH
        run_op(3'd4, 4'd2, 8'h00, 1'b0, 1'b0, 1'b0);
        run_op(3'd0, 4'd7, 8'h00, 1'b0, 1'b0, 1'b0);
        run_op(3'd7, 4'd3, 8'h00, 1'b0, 1'b0, 1'b0);
        run_op(3'd3, 4'd0, 8'h80, 1'b0, 1'b0, 1'b0);
        run_op(3'd6, 4'd15, 8'h00, 1'b0, 1'b0, 1'b0);  // ASR saturates -> FF
        chk("asr_sat", 32'(q), 32'hFF);
        run_op(3'd2, 4'd15, 8'h00, 1'b0, 1'b0, 1'b0);  // SLL fills with zeros -> 00
        run_op(3'd3, 4'd0, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(3'd4, 4'd9, 8'h00, 1'b0, 1'b0, 1'b0);   // ROR 9 == ROR 1 -> 80
        chk("ror9_abs", 32'(q), 32'h80);

        // reset during the 2nd step of a 6-step shift
        @(negedge clk);
        run_op_abort();
        run_op(3'd3, 4'd0, 8'h3C, 1'b0, 1'b0, 1'b0);
        run_op(3'd4, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0);   // -> 1E
        chk("post_rst_ror", 32'(q), 32'h1E);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    task automatic run_op_abort();
        start = 1'b1; mode = 3'd1; amount = 4'd6; sin_r = 1'b1;
        @(negedge clk);                 // accepted, busy
        start = 1'b0;
        chk("abort_busy", 32'(busy), 32'd1);
        @(negedge clk);                 // first step done
        rst = 1'b1;                     // reset takes the second step edge
        @(negedge clk);
        rst = 1'b0;
        chk("abort_q", 32'(q), 32'h00);
        chk("abort_busy0", 32'(busy), 32'd0);
        chk("abort_done0", 32'(done), 32'd0);
        @(negedge clk);
        chk("abort_nodone", 32'(done), 32'd0);
        chk("abort_q_hold", 32'(q), 32'h00);
        mdl_q = 8'h00;
    endtask

endmodule
